// File: rtl/lcd_text_scheduler_if.sv
// Write-request port of the LCD text scheduler: two level requesters with
// one-cycle acknowledge pulses.
interface lcd_text_scheduler_if;
    logic       REQ0;
    logic       REQ1;
    logic [4:0] ADDR0;
    logic [4:0] ADDR1;
    logic [7:0] CHAR0;
    logic [7:0] CHAR1;
    logic       ACK0;
    logic       ACK1;

    modport master (
        output REQ0, REQ1, ADDR0, ADDR1, CHAR0, CHAR1,
        input  ACK0, ACK1
    );

    modport slave (
        input  REQ0, REQ1, ADDR0, ADDR1, CHAR0, CHAR1,
        output ACK0, ACK1
    );
endinterface

// File: rtl/lcd_text_scheduler.sv
// 2x16 character LCD text buffer with round-robin write arbitration, one-shot
// power-up init and repeating refresh frames. Optional: LCD_DIRTY_SKIP_EN.
module lcd_text_scheduler #(
    parameter int unsigned PWR_DELAY  = 70,
    parameter int unsigned WR_CYCLES  = 20,
    parameter int unsigned E_SETUP    = 2,
    parameter int unsigned E_WIDTH    = 8,
    parameter int unsigned CLR_WAIT   = 200,
    parameter int unsigned GAP_CYCLES = 400
) (
    input  logic                       CLK,
    input  logic                       RESETN,
    lcd_text_scheduler_if.slave        wr,
    output logic                       LCD_E,
    output logic                       LCD_RS,
    output logic                       LCD_RW,
    output logic [7:0]                 LCD_DATA,
    output logic                       INIT_DONE,
    output logic                       FRAME_DONE
);

    typedef enum logic [3:0] {
        StPwrWait, StFuncSet, StDispOn, StEntry, StClear,
        StAddr1, StLine1, StAddr2, StLine2, StGap
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  idx_q, idx_d;
    logic        dirty_q, dirty_d;
    logic        rr_q, rr_d;
    logic [7:0]  buf_q [32];

    logic        e_d, rs_d, init_done_d, frame_done_d;
    logic [7:0]  data_d;
    logic        gnt0, gnt1;
    logic        slot_last;
    logic        is_slot;

    // Arbitration: contention goes to rr_q, which then flips.
    always_comb begin
        gnt0 = wr.REQ0 && (!wr.REQ1 || !rr_q);
        gnt1 = wr.REQ1 && (!wr.REQ0 || rr_q);
        rr_d = (wr.REQ0 && wr.REQ1) ? ~rr_q : rr_q;
    end

    assign wr.ACK0 = gnt0;
    assign wr.ACK1 = gnt1;
    assign LCD_RW  = 1'b0;

    always_ff @(posedge CLK or posedge RESETN) begin
        if (RESETN) begin
            for (int i = 0; i < 32; i++) buf_q[i] <= 8'h20;
        end else if (gnt0) begin
            buf_q[wr.ADDR0] <= wr.CHAR0;
        end else if (gnt1) begin
            buf_q[wr.ADDR1] <= wr.CHAR1;
        end
    end

    // State and registered LCD outputs.
    always_ff @(posedge CLK or posedge RESETN) begin
        if (RESETN) begin
            state_q    <= StPwrWait;
            cnt_q      <= '0;
            idx_q      <= '0;
            dirty_q    <= 1'b1;
            rr_q       <= 1'b0;
            LCD_E      <= 1'b0;
            LCD_RS     <= 1'b0;
            LCD_DATA   <= 8'h00;
            INIT_DONE  <= 1'b0;
            FRAME_DONE <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            dirty_q    <= dirty_d;
            rr_q       <= rr_d;
            LCD_E      <= e_d;
            LCD_RS     <= rs_d;
            LCD_DATA   <= data_d;
            INIT_DONE  <= init_done_d;
            FRAME_DONE <= frame_done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 16'd1;
        idx_d     = idx_q;
        slot_last = (cnt_q == 16'(WR_CYCLES - 1));
        case (state_q)
            StPwrWait: if (cnt_q == 16'(PWR_DELAY - 1)) begin
                state_d = StFuncSet;
                cnt_d   = '0;
            end
            StFuncSet: if (slot_last) begin
                state_d = StDispOn;
                cnt_d   = '0;
            end
            StDispOn: if (slot_last) begin
                state_d = StEntry;
                cnt_d   = '0;
            end
            StEntry: if (slot_last) begin
                state_d = StClear;
                cnt_d   = '0;
            end
            StClear: if (cnt_q == 16'(WR_CYCLES + CLR_WAIT - 1)) begin
                state_d = StAddr1;
                cnt_d   = '0;
            end
            StAddr1: if (slot_last) begin
                state_d = StLine1;
                cnt_d   = '0;
                idx_d   = '0;
            end
            StLine1: if (slot_last) begin
                cnt_d = '0;
                if (idx_q == 4'd15) state_d = StAddr2;
                else                idx_d   = idx_q + 4'd1;
            end
            StAddr2: if (slot_last) begin
                state_d = StLine2;
                cnt_d   = '0;
                idx_d   = '0;
            end
            StLine2: if (slot_last) begin
                cnt_d = '0;
                if (idx_q == 4'd15) state_d = StGap;
                else                idx_d   = idx_q + 4'd1;
            end
            StGap: if (cnt_q == 16'(GAP_CYCLES - 1)) begin
                cnt_d = '0;
`ifdef LCD_DIRTY_SKIP_EN
                // Nothing changed since the last frame: idle for another gap.
                if (dirty_q) state_d = StAddr1;
`else
                state_d = StAddr1;
`endif
            end
            default: begin
                state_d = StPwrWait;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are computed from the next state so they are registered at slot cycle 0.
    always_comb begin
        e_d          = 1'b0;
        rs_d         = LCD_RS;
        data_d       = LCD_DATA;
        is_slot      = (state_d != StPwrWait) && (state_d != StGap);
        init_done_d  = INIT_DONE || (state_d == StAddr1);
        frame_done_d = (state_d == StLine2) && (idx_d == 4'd15) &&
                       (cnt_d == 16'(WR_CYCLES - 1));
        if (gnt0 || gnt1)                                 dirty_d = 1'b1;
        else if (state_d == StAddr1 && state_q != StAddr1) dirty_d = 1'b0;
        else                                              dirty_d = dirty_q;
        if (is_slot) begin
            e_d = (cnt_d >= 16'(E_SETUP)) && (cnt_d < 16'(E_SETUP + E_WIDTH));
        end
        if (is_slot && cnt_d == '0) begin
            rs_d = 1'b0;
            case (state_d)
                StFuncSet: data_d = 8'h38;
                StDispOn:  data_d = 8'h0C;
                StEntry:   data_d = 8'h06;
                StClear:   data_d = 8'h01;
                StAddr1:   data_d = 8'h80;
                StAddr2:   data_d = 8'hC0;
                StLine1: begin
                    rs_d   = 1'b1;
                    data_d = buf_q[{1'b0, idx_d}];
                end
                StLine2: begin
                    rs_d   = 1'b1;
                    data_d = buf_q[{1'b1, idx_d}];
                end
                default: data_d = LCD_DATA;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_text_scheduler.sv
// Directed bench for lcd_text_scheduler; cycle numbers count clocks since reset release.
module tb_lcd_text_scheduler;
    logic       CLK = 1'b0;
    logic       RESETN = 1'b1;
    logic       LCD_E, LCD_RS, LCD_RW, INIT_DONE, FRAME_DONE;
    logic [7:0] LCD_DATA;
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;

    lcd_text_scheduler_if wr();

    lcd_text_scheduler dut (
        .CLK       (CLK),
        .RESETN    (RESETN),
        .wr        (wr),
        .LCD_E     (LCD_E),
        .LCD_RS    (LCD_RS),
        .LCD_RW    (LCD_RW),
        .LCD_DATA  (LCD_DATA),
        .INIT_DONE (INIT_DONE),
        .FRAME_DONE(FRAME_DONE)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (RESETN) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: cyc=%0d required finish", cyc);
        $fatal(1);
    end

    task automatic goto(input int t);
        while (cyc < t) @(negedge CLK);
    endtask

    task automatic drive(input bit r0, input bit r1, input logic [4:0] a0, input logic [4:0] a1,
                         input logic [7:0] c0, input logic [7:0] c1);
        wr.REQ0 = r0; wr.REQ1 = r1; wr.ADDR0 = a0; wr.ADDR1 = a1; wr.CHAR0 = c0; wr.CHAR1 = c1;
    endtask

    task automatic test_reset;
        drive(0, 0, 5'd0, 5'd0, 8'h00, 8'h00);
        repeat (2) @(negedge CLK);
        total++;
        if ({LCD_E, LCD_RS, LCD_RW, LCD_DATA, INIT_DONE, FRAME_DONE} !== 13'h0) begin
            bad++;
            $display("FAIL reset_outputs: got E%b RS%b RW%b D%h I%b F%b want all 0",
                     LCD_E, LCD_RS, LCD_RW, LCD_DATA, INIT_DONE, FRAME_DONE);
        end
        RESETN = 1'b0;
    endtask

    task automatic test_init;
        bit hi = 0;
        for (int t = 0; t < 70; t++) begin
            goto(t);
            if (LCD_E !== 1'b0) hi = 1;
        end
        total++;
        if (hi) begin bad++; $display("FAIL pwr_wait_e_low: got E high want low"); end
        goto(70);
        total++;
        if ({LCD_E, LCD_RS, LCD_DATA} !== {1'b0, 1'b0, 8'h38}) begin
            bad++; $display("FAIL func_set_setup: got %b %b %h want 0 0 38", LCD_E, LCD_RS, LCD_DATA);
        end
        goto(72);
        total++;
        if ({LCD_E, LCD_RS, LCD_DATA} !== {1'b1, 1'b0, 8'h38}) begin
            bad++; $display("FAIL func_set_e: got %b %b %h want 1 0 38", LCD_E, LCD_RS, LCD_DATA);
        end
        goto(80);
        total++;
        if (LCD_E !== 1'b0) begin bad++; $display("FAIL e_width: got %b want 0", LCD_E); end
        goto(92);
        total++;
        if ({LCD_E, LCD_RS, LCD_DATA} !== {1'b1, 1'b0, 8'h0C}) begin
            bad++; $display("FAIL disp_on: got %b %b %h want 1 0 0c", LCD_E, LCD_RS, LCD_DATA);
        end
        goto(112);
        total++;
        if ({LCD_E, LCD_RS, LCD_DATA} !== {1'b1, 1'b0, 8'h06}) begin
            bad++; $display("FAIL entry: got %b %b %h want 1 0 06", LCD_E, LCD_RS, LCD_DATA);
        end
        goto(132);
        total++;
        if ({LCD_E, LCD_RS, LCD_DATA} !== {1'b1, 1'b0, 8'h01}) begin
            bad++; $display("FAIL clear: got %b %b %h want 1 0 01", LCD_E, LCD_RS, LCD_DATA);
        end
        goto(349);
        total++;
        if (INIT_DONE !== 1'b0) begin bad++; $display("FAIL init_done_early: got %b want 0", INIT_DONE); end
        goto(352);
        total++;
        if ({INIT_DONE, LCD_E, LCD_RS, LCD_DATA} !== {1'b1, 1'b1, 1'b0, 8'h80}) begin
            bad++;
            $display("FAIL addr1_slot: got I%b %b %b %h want 1 1 0 80", INIT_DONE, LCD_E, LCD_RS, LCD_DATA);
        end
    endtask

    task automatic test_write;
        goto(400);
        drive(1, 0, 5'd3, 5'd0, 8'h41, 8'h00);
        #1;
        total++;
        if ({wr.ACK0, wr.ACK1} !== 2'b10) begin
            bad++; $display("FAIL single_ack: got %b%b want 10", wr.ACK0, wr.ACK1);
        end
        goto(401);
        drive(0, 0, 5'd0, 5'd0, 8'h00, 8'h00);
        #1;
        total++;
        if (wr.ACK0 !== 1'b0) begin bad++; $display("FAIL ack_pulse: got %b want 0", wr.ACK0); end
        goto(412);
        total++;
        if ({LCD_E, LCD_RS, LCD_DATA} !== {1'b1, 1'b1, 8'h20}) begin
            bad++; $display("FAIL slot2_blank: got %b %b %h want 1 1 20", LCD_E, LCD_RS, LCD_DATA);
        end
        goto(432);
        total++;
        if ({LCD_E, LCD_RS, LCD_DATA} !== {1'b1, 1'b1, 8'h41}) begin
            bad++; $display("FAIL slot3_char: got %b %b %h want 1 1 41", LCD_E, LCD_RS, LCD_DATA);
        end
    endtask

    task automatic test_arbitration;
        goto(500);
        drive(1, 1, 5'd4, 5'd5, 8'h42, 8'h43);
        #1;
        total++;
        if ({wr.ACK0, wr.ACK1} !== 2'b10) begin
            bad++; $display("FAIL arb_first_pair: got %b%b want 10", wr.ACK0, wr.ACK1);
        end
        goto(501);
        drive(0, 1, 5'd4, 5'd5, 8'h42, 8'h43);
        #1;
        total++;
        if ({wr.ACK0, wr.ACK1} !== 2'b01) begin
            bad++; $display("FAIL arb_second_grant: got %b%b want 01", wr.ACK0, wr.ACK1);
        end
        goto(502);
        drive(1, 1, 5'd6, 5'd7, 8'h44, 8'h45);
        #1;
        total++;
        if ({wr.ACK0, wr.ACK1} !== 2'b01) begin
            bad++; $display("FAIL arb_flipped_pair: got %b%b want 01", wr.ACK0, wr.ACK1);
        end
        goto(503);
        drive(1, 0, 5'd6, 5'd7, 8'h44, 8'h45);
        #1;
        total++;
        if ({wr.ACK0, wr.ACK1} !== 2'b10) begin
            bad++; $display("FAIL arb_leftover: got %b%b want 10", wr.ACK0, wr.ACK1);
        end
        goto(504);
        drive(0, 0, 5'd0, 5'd0, 8'h00, 8'h00);
    endtask

    task automatic test_frame;
        logic [7:0] exp_ch [4];
        exp_ch[0] = 8'h42; exp_ch[1] = 8'h43; exp_ch[2] = 8'h44; exp_ch[3] = 8'h45;
        goto(1028);
        total++;
        if (FRAME_DONE !== 1'b0) begin bad++; $display("FAIL frame_done_early: got %b want 0", FRAME_DONE); end
        goto(1029);
        total++;
        if (FRAME_DONE !== 1'b1) begin bad++; $display("FAIL frame_done: got %b want 1", FRAME_DONE); end
        goto(1030);
        total++;
        if (FRAME_DONE !== 1'b0) begin bad++; $display("FAIL frame_done_pulse: got %b want 0", FRAME_DONE); end
        goto(1200);
        total++;
        if (LCD_E !== 1'b0) begin bad++; $display("FAIL gap_e_low: got %b want 0", LCD_E); end
        goto(1432);
        total++;
        if ({LCD_E, LCD_RS, LCD_DATA} !== {1'b1, 1'b0, 8'h80}) begin
            bad++; $display("FAIL frame2_addr1: got %b %b %h want 1 0 80", LCD_E, LCD_RS, LCD_DATA);
        end
        goto(1512);
        total++;
        if ({LCD_RS, LCD_DATA} !== {1'b1, 8'h41}) begin
            bad++; $display("FAIL frame2_slot3: got %b %h want 1 41", LCD_RS, LCD_DATA);
        end
        for (int k = 0; k < 4; k++) begin
            goto(1532 + 20 * k);
            total++;
            if ({LCD_E, LCD_RS, LCD_DATA} !== {1'b1, 1'b1, exp_ch[k]}) begin
                bad++;
                $display("FAIL frame2_arb_slot%0d: got %b %b %h want 1 1 %h",
                         k + 4, LCD_E, LCD_RS, LCD_DATA, exp_ch[k]);
            end
        end
    endtask

    task automatic test_same_cycle;
        goto(1810);
        drive(0, 1, 5'd0, 5'd17, 8'h00, 8'h5A);
        #1;
        total++;
        if (wr.ACK1 !== 1'b1) begin bad++; $display("FAIL late_write_ack: got %b want 1", wr.ACK1); end
        goto(1811);
        drive(0, 0, 5'd0, 5'd0, 8'h00, 8'h00);
        goto(1812);
        total++;
        if ({LCD_RS, LCD_DATA} !== {1'b1, 8'h20}) begin
            bad++; $display("FAIL late_write_old: got %b %h want 1 20", LCD_RS, LCD_DATA);
        end
        goto(2892);
        total++;
        if ({LCD_E, LCD_RS, LCD_DATA} !== {1'b1, 1'b1, 8'h5A}) begin
            bad++; $display("FAIL late_write_next: got %b %b %h want 1 1 5a", LCD_E, LCD_RS, LCD_DATA);
        end
        goto(2900);
        drive(1, 0, 5'd31, 5'd0, 8'h21, 8'h00);
        #1;
        total++;
        if (wr.ACK0 !== 1'b1) begin bad++; $display("FAIL refresh_write_ack: got %b want 1", wr.ACK0); end
        goto(2901);
        drive(0, 0, 5'd0, 5'd0, 8'h00, 8'h00);
    endtask

    task automatic test_mid_reset;
        goto(3614);
        total++;
        if (LCD_E !== 1'b1) begin bad++; $display("FAIL pre_reset_e: got %b want 1", LCD_E); end
        RESETN = 1'b1;
        #1;
        total++;
        if ({LCD_E, LCD_RS, LCD_DATA, INIT_DONE} !== 11'h0) begin
            bad++;
            $display("FAIL mid_reset_outputs: got E%b RS%b D%h I%b want 0", LCD_E, LCD_RS, LCD_DATA, INIT_DONE);
        end
        @(negedge CLK);
        RESETN = 1'b0;
        goto(72);
        total++;
        if ({LCD_E, LCD_RS, LCD_DATA} !== {1'b1, 1'b0, 8'h38}) begin
            bad++; $display("FAIL reinit_func_set: got %b %b %h want 1 0 38", LCD_E, LCD_RS, LCD_DATA);
        end
        goto(352);
        total++;
        if ({INIT_DONE, LCD_DATA} !== {1'b1, 8'h80}) begin
            bad++; $display("FAIL reinit_addr1: got I%b %h want 1 80", INIT_DONE, LCD_DATA);
        end
        goto(432);
        total++;
        if ({LCD_RS, LCD_DATA} !== {1'b1, 8'h20}) begin
            bad++; $display("FAIL buffer_cleared: got %b %h want 1 20", LCD_RS, LCD_DATA);
        end
    endtask

`ifdef LCD_DIRTY_SKIP_EN
    task automatic test_dirty_skip;
        bit e_hi = 0;
        bit fd_hi = 0;
        for (int t = 1030; t < 2230; t++) begin
            goto(t);
            if (LCD_E !== 1'b0) e_hi = 1;
            if (FRAME_DONE !== 1'b0) fd_hi = 1;
            if (t == 2100) drive(1, 0, 5'd0, 5'd0, 8'h78, 8'h00);
            if (t == 2101) drive(0, 0, 5'd0, 5'd0, 8'h00, 8'h00);
        end
        total++;
        if (e_hi) begin bad++; $display("FAIL skip_e_idle: got E high want low"); end
        total++;
        if (fd_hi) begin bad++; $display("FAIL skip_frame_done: got pulse want none"); end
        goto(2232);
        total++;
        if ({LCD_E, LCD_RS, LCD_DATA} !== {1'b1, 1'b0, 8'h80}) begin
            bad++; $display("FAIL skip_resume: got %b %b %h want 1 0 80", LCD_E, LCD_RS, LCD_DATA);
        end
    endtask
`else
    task automatic test_continuous;
        goto(1432);
        total++;
        if ({LCD_E, LCD_RS, LCD_DATA} !== {1'b1, 1'b0, 8'h80}) begin
            bad++; $display("FAIL continuous_refresh: got %b %b %h want 1 0 80", LCD_E, LCD_RS, LCD_DATA);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_init();
        test_write();
        test_arbitration();
        test_frame();
        test_same_cycle();
        test_mid_reset();
`ifdef LCD_DIRTY_SKIP_EN
        test_dirty_skip();
`else
        test_continuous();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
